// File: rtl/superfx_pkg.sv
// Shared constants, state type and small helpers for the SuperFX GO/IRQ control stage.
package superfx_pkg;

    localparam logic [15:0] ADDR_R15_HI = 16'h301F;
    localparam logic [15:0] ADDR_SFR_LO = 16'h3030;
    localparam logic [15:0] ADDR_SFR_HI = 16'h3031;
    localparam int          SFR_G_BIT   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } go_irq_state_t;

    // Level presented on the SNES /IRQ pin for a given flag and mask.
    function automatic logic irq_pin_n(input logic irq_flag, input logic mask);
        return ~(irq_flag & ~mask);
    endfunction

endpackage

// File: rtl/superfx_go_irq_ctrl_strobe_sync_edge.sv
// Synchronizes an asynchronous SNES strobe into clk and emits registered
// one-cycle rise/fall pulses.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   sync_out_s;

    assign sync_out_s = sync_q[SYNC_STAGES-1];

    // Next-state for the synchronizer chain and edge detector.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], strobe};
        prev_d = sync_out_s;
        rise_d = sync_out_s & ~prev_q;
        fall_d = ~sync_out_s & prev_q;
    end

    // Synchronizer, edge history and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/superfx_go_irq_ctrl.sv
// GO/IRQ flag generation for the SuperFX SFR: decodes synchronized SNES bus
// accesses and core STOP events into a registered run/drain state machine.
module superfx_go_irq_ctrl
    import superfx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snes_wr,
    input  logic        snes_rd,
    input  logic [15:0] snes_addr,
    input  logic [7:0]  snes_wdata,
    input  logic        core_stop,
    input  logic        core_busy,
    input  logic        irq_mask,
    output logic        go,
    output logic        irq,
    output logic        irq_n,
    output logic [1:0]  state
);

    logic          wr_rise_s;
    logic          wr_fall_unused_s;
    logic          rd_rise_unused_s;
    logic          rd_fall_s;
    logic          wdata_unused_s;

    logic          start_s;
    logic          abort_s;
    logic          irq_clr_s;
    logic          irq_set_s;
    logic          pending_eff_s;

    go_irq_state_t state_q;
    go_irq_state_t state_d;
    logic          start_pending_q;
    logic          start_pending_d;
    logic          go_q;
    logic          go_d;
    logic          irq_q;
    logic          irq_d;
    logic          irq_n_q;
    logic          irq_n_d;

    strobe_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_wr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .strobe(snes_wr),
        .rise  (wr_rise_s),
        .fall  (wr_fall_unused_s)
    );

    strobe_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .strobe(snes_rd),
        .rise  (rd_rise_unused_s),
        .fall  (rd_fall_s)
    );

    // Only the G bit of the SFR low byte matters to this stage.
    assign wdata_unused_s = ^{snes_wdata[7:SFR_G_BIT+1], snes_wdata[SFR_G_BIT-1:0]};

    // Bus event decode; address and data are sampled in the pulse cycle.
    always_comb begin
        start_s   = 1'b0;
        abort_s   = 1'b0;
        irq_clr_s = 1'b0;
        if (wr_rise_s) begin
            if (snes_addr == ADDR_R15_HI) begin
                start_s = 1'b1;
            end else if (snes_addr == ADDR_SFR_LO) begin
                start_s = snes_wdata[SFR_G_BIT];
                abort_s = ~snes_wdata[SFR_G_BIT];
            end else begin
                start_s = 1'b0;
            end
        end else begin
            start_s = 1'b0;
        end
        if (rd_fall_s && (snes_addr == ADDR_SFR_HI)) begin
            irq_clr_s = 1'b1;
        end else begin
            irq_clr_s = 1'b0;
        end
    end

    // Run/drain state transitions; a start seen during drain is deferred
    // to the drain exit unless a later abort cancels it.
    always_comb begin
        state_d         = state_q;
        start_pending_d = start_pending_q;
        irq_set_s       = 1'b0;
        pending_eff_s   = start_pending_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (core_stop) begin
                    state_d         = DRAIN;
                    start_pending_d = 1'b0;
                end else if (abort_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (abort_s) begin
                    pending_eff_s = 1'b0;
                end else if (start_s) begin
                    pending_eff_s = 1'b1;
                end else begin
                    pending_eff_s = start_pending_q;
                end
                if (!core_busy) begin
                    irq_set_s       = 1'b1;
                    state_d         = pending_eff_s ? RUN : IDLE;
                    start_pending_d = 1'b0;
                end else begin
                    state_d         = DRAIN;
                    start_pending_d = pending_eff_s;
                end
            end
            default: begin
                state_d         = IDLE;
                start_pending_d = 1'b0;
            end
        endcase
    end

    // Flag next-state: a new IRQ event beats a simultaneous clear.
    always_comb begin
        go_d = (state_d == RUN);
        if (irq_set_s) begin
            irq_d = 1'b1;
        end else if (irq_clr_s) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
        irq_n_d = irq_pin_n(irq_q, irq_mask);
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            start_pending_q <= 1'b0;
            go_q            <= 1'b0;
            irq_q           <= 1'b0;
            irq_n_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            start_pending_q <= start_pending_d;
            go_q            <= go_d;
            irq_q           <= irq_d;
            irq_n_q         <= irq_n_d;
        end
    end

    assign go    = go_q;
    assign irq   = irq_q;
    assign irq_n = irq_n_q;
    assign state = state_q;

endmodule

// File: tb/tb_superfx_go_irq_ctrl.sv
// Directed bench for superfx_go_irq_ctrl: a sample-history reference model
// checked every cycle, plus literal expectations at key points.
module tb_superfx_go_irq_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snes_wr = 1'b0;
    logic        snes_rd = 1'b0;
    logic [15:0] snes_addr = 16'h0000;
    logic [7:0]  snes_wdata = 8'h00;
    logic        core_stop = 1'b0;
    logic        core_busy = 1'b0;
    logic        irq_mask = 1'b0;
    logic        go;
    logic        irq;
    logic        irq_n;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail = 0;

    superfx_go_irq_ctrl #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .snes_wr   (snes_wr),
        .snes_rd   (snes_rd),
        .snes_addr (snes_addr),
        .snes_wdata(snes_wdata),
        .core_stop (core_stop),
        .core_busy (core_busy),
        .irq_mask  (irq_mask),
        .go        (go),
        .irq       (irq),
        .irq_n     (irq_n),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: an event reaches the flags S+1 edges after the strobe
    // edge is first sampled, i.e. GO rises on edge S+2 after a write begins.
    int         m_state;
    logic       m_go, m_irq, m_irqn, m_pend;
    logic [7:0] wr_h, rd_h;

    initial begin
        logic ev_wr, ev_rd, st, ab, clr, setirq, new_irqn;
        m_state = 0; m_go = 0; m_irq = 0; m_irqn = 1; m_pend = 0;
        wr_h = 8'h00; rd_h = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_go = 0; m_irq = 0; m_irqn = 1; m_pend = 0;
                wr_h = 8'h00; rd_h = 8'h00;
            end else begin
                wr_h = {wr_h[6:0], snes_wr};
                rd_h = {rd_h[6:0], snes_rd};
                ev_wr = wr_h[S+1] && !wr_h[S+2];
                ev_rd = !rd_h[S+1] && rd_h[S+2];
                st  = ev_wr && (snes_addr == 16'h301F ||
                                (snes_addr == 16'h3030 && snes_wdata[5]));
                ab  = ev_wr && snes_addr == 16'h3030 && !snes_wdata[5];
                clr = ev_rd && snes_addr == 16'h3031;
                setirq = 1'b0;
                new_irqn = !(m_irq && !irq_mask);
                if (m_state == 0) begin
                    if (st) m_state = 1;
                end else if (m_state == 1) begin
                    if (core_stop) m_state = 2;
                    else if (ab) m_state = 0;
                end else begin
                    if (st) m_pend = 1;
                    if (ab) m_pend = 0;
                    if (!core_busy) begin
                        setirq = 1'b1;
                        m_state = m_pend ? 1 : 0;
                        m_pend = 0;
                    end
                end
                if (setirq) m_irq = 1;
                else if (clr) m_irq = 0;
                m_go = (m_state == 1);
                m_irqn = new_irqn;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_state", {6'd0, state}, m_state[7:0]);
            chk("model_go", {7'd0, go}, {7'd0, m_go});
            chk("model_irq", {7'd0, irq}, {7'd0, m_irq});
            chk("model_irq_n", {7'd0, irq_n}, {7'd0, m_irqn});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        snes_addr = a; snes_wdata = d; snes_wr = 1'b1;
        step(3);
        snes_wr = 1'b0;
        step(6);
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("reset_state", {6'd0, state}, 8'd0);
        chk("reset_irq_n", {7'd0, irq_n}, 8'd1);

        // Start via R15 high byte: GO on the 4th edge.
        snes_addr = 16'h301F; snes_wdata = 8'h00; snes_wr = 1'b1;
        step(3);
        chk("start_latency_go_low", {7'd0, go}, 8'd0);
        step(1);
        chk("start_go", {7'd0, go}, 8'd1);
        chk("start_state", {6'd0, state}, 8'd1);
        snes_wr = 1'b0;
        step(6);

        // Stop with a three-cycle drain.
        core_busy = 1'b1; core_stop = 1'b1;
        step(1);
        core_stop = 1'b0;
        chk("stop_go", {7'd0, go}, 8'd0);
        chk("stop_state", {6'd0, state}, 8'd2);
        step(2);
        chk("drain_state", {6'd0, state}, 8'd2);
        core_busy = 1'b0;
        step(1);
        chk("drain_exit_state", {6'd0, state}, 8'd0);
        chk("drain_exit_irq", {7'd0, irq}, 8'd1);
        chk("drain_exit_irq_n_lag", {7'd0, irq_n}, 8'd1);
        step(1);
        chk("drain_irq_n", {7'd0, irq_n}, 8'd0);
        step(2);

        // Read completion coincident with drain exit: set wins.
        do_write(16'h301F, 8'h00);
        snes_addr = 16'h3031; snes_rd = 1'b1; core_busy = 1'b1; core_stop = 1'b1;
        step(1);
        core_stop = 1'b0;
        step(1);
        snes_rd = 1'b0;
        step(3);
        core_busy = 1'b0;
        step(1);
        chk("race_irq", {7'd0, irq}, 8'd1);
        chk("race_state", {6'd0, state}, 8'd0);
        step(4);

        // Read completion alone clears.
        snes_rd = 1'b1;
        step(3);
        snes_rd = 1'b0;
        step(3);
        chk("clr_irq_before", {7'd0, irq}, 8'd1);
        step(1);
        chk("clr_irq", {7'd0, irq}, 8'd0);
        step(1);
        chk("clr_irq_n", {7'd0, irq_n}, 8'd1);
        step(4);

        // Deferred start during drain.
        do_write(16'h301F, 8'h00);
        core_busy = 1'b1; core_stop = 1'b1;
        step(1);
        core_stop = 1'b0;
        do_write(16'h3030, 8'h20);
        chk("defer_wait_state", {6'd0, state}, 8'd2);
        core_busy = 1'b0;
        step(1);
        chk("defer_state", {6'd0, state}, 8'd1);
        chk("defer_go", {7'd0, go}, 8'd1);
        chk("defer_irq", {7'd0, irq}, 8'd1);
        step(2);

        // Deferred start cancelled by a later abort.
        core_busy = 1'b1; core_stop = 1'b1;
        step(1);
        core_stop = 1'b0;
        do_write(16'h3030, 8'h20);
        do_write(16'h3030, 8'h00);
        core_busy = 1'b0;
        step(1);
        chk("cancel_state", {6'd0, state}, 8'd0);
        chk("cancel_go", {7'd0, go}, 8'd0);
        step(2);

        // Mask affects only the pin, one cycle later.
        chk("mask_pre_irq_n", {7'd0, irq_n}, 8'd0);
        irq_mask = 1'b1;
        step(1);
        chk("mask_irq_n", {7'd0, irq_n}, 8'd1);
        chk("mask_irq", {7'd0, irq}, 8'd1);
        irq_mask = 1'b0;
        step(1);
        chk("unmask_irq_n", {7'd0, irq_n}, 8'd0);

        // Abort in RUN leaves irq alone; unmapped address does nothing.
        do_write(16'h301F, 8'h00);
        chk("run_go", {7'd0, go}, 8'd1);
        do_write(16'h3030, 8'h00);
        chk("abort_go", {7'd0, go}, 8'd0);
        chk("abort_irq", {7'd0, irq}, 8'd1);
        do_write(16'h3032, 8'h20);
        chk("unmapped_state", {6'd0, state}, 8'd0);

        // Drain entered with core idle lasts one cycle.
        do_write(16'h301F, 8'h00);
        core_stop = 1'b1;
        step(1);
        core_stop = 1'b0;
        chk("short_drain_state", {6'd0, state}, 8'd2);
        step(1);
        chk("short_drain_exit", {6'd0, state}, 8'd0);

        // Reset mid-RUN with irq set.
        do_write(16'h301F, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_go", {7'd0, go}, 8'd0);
        chk("rst_irq", {7'd0, irq}, 8'd0);
        chk("rst_irq_n", {7'd0, irq_n}, 8'd1);
        chk("rst_state", {6'd0, state}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8);
        chk("post_rst_state", {6'd0, state}, 8'd0);
        chk("post_rst_irq", {7'd0, irq}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/superfx_go_irq_ctrl.md
Name: superfx_go_irq_ctrl

Overview:
- Clocked control stage that generates the GO and IRQ status flags of the SuperFX SFR from SNES-bus register accesses and core STOP events.
- Resolves set/clear conflicts synchronously and feeds the SFR readback path and the SNES /IRQ pin.
- Sits between the SNES bus interface (upstream) and the flag storage/readback plus core enable logic (downstream).
- Replaces direct set/reset drive of asynchronous latches with a registered state machine.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SNES strobe synchronizers; legal range 2..4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- snes_wr  in  1  SNES write strobe, active high, asynchronous to clk
- snes_rd  in  1  SNES read strobe, active high, asynchronous to clk
- snes_addr  in  16  register address; stable from strobe rise until SYNC_STAGES+2 clk after strobe fall
- snes_wdata  in  8  write data; same stability as snes_addr
- core_stop  in  1  one-cycle pulse, core executed STOP
- core_busy  in  1  core pipeline not yet drained
- irq_mask  in  1  CFGR IRQ mask; 1 = /IRQ pin suppressed
- go  out  1  SFR G flag; core run enable
- irq  out  1  SFR IRQ flag (unmasked)
- irq_n  out  1  SNES /IRQ pin, active low, registered
- state  out  2  current FSM state, for debug and readback

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n, as the codebase does.
  - While rst_n=0: state=IDLE, go=0, irq=0, irq_n=1, start_pending=0, all synchronizer and edge flops 0.
  - Reset mid-operation abandons any drain in progress. No IRQ is generated.
- Strobe handling:
  - snes_wr and snes_rd each pass through a SYNC_STAGES synchronizer.
  - Write event: one-cycle pulse on the synchronized rising edge of snes_wr. snes_addr and snes_wdata are sampled in that cycle.
  - Read-complete event: one-cycle pulse on the synchronized falling edge of snes_rd, with snes_addr sampled in that cycle.
- Decoded events:
  - start: write to 16'h301F (R15 high byte), or write to 16'h3030 with wdata[5]=1.
  - abort: write to 16'h3030 with wdata[5]=0.
  - irq_clr: read-complete at 16'h3031.
- FSM states, encoding 0..2:
  - IDLE (go=0):
    - start -> RUN.
    - abort ignored.
  - RUN (go=1):
    - core_stop -> DRAIN.
    - abort -> IDLE, no IRQ.
    - core_stop and abort in the same cycle -> DRAIN (stop wins; IRQ will be raised).
    - start while in RUN has no effect.
  - DRAIN (go=0):
    - Waits for core_busy=0.
    - On the first cycle with core_busy=0: irq set.
      - If start_pending=1, next state is RUN and start_pending clears.
      - Otherwise next state is IDLE.
    - start during DRAIN sets start_pending; it is deferred, not lost.
    - abort during DRAIN clears start_pending.
    - A DRAIN entered with core_busy already 0 exits after exactly one cycle.
- Flag outputs:
  - go is registered and equals (next_state==RUN).
  - Latency: go rises at the (SYNC_STAGES+2)th rising clk edge after snes_wr is first sampled high.
  - go falls on the first edge after core_stop is sampled.
- IRQ flag:
  - Set on DRAIN exit.
  - Cleared by irq_clr.
  - Set and clear in the same cycle: set wins, so a new event is never lost.
  - irq holds across IDLE/RUN transitions until cleared.
- irq_n: registered ~(irq & ~irq_mask), one cycle behind irq.
  - A change of irq_mask reflects on irq_n one cycle later.
  - irq itself is unaffected by the mask.
- Unmapped addresses produce no events.
- Back-to-back strobes closer than SYNC_STAGES+1 clk may merge. The SNES bus timing guarantees they do not occur.

Decomposition:
- Shared package superfx_pkg:
  - Address constants ADDR_R15_HI=16'h301F, ADDR_SFR_LO=16'h3030, ADDR_SFR_HI=16'h3031.
  - SFR_G_BIT=5.
  - The go_irq_state_t enum {IDLE=0, RUN=1, DRAIN=2}.
- Sub-module strobe_sync_edge:
  - Parameter SYNC_STAGES.
  - Outputs rise and fall pulses.
  - Instanced twice: once for snes_wr, once for snes_rd.

Test Plan:
- Reset: rst_n low mid-RUN with irq=1 -> immediately go=0, irq=0, irq_n=1, state=0; no pulses after release.
- Start via R15: write 16'h301F data 8'h00, SYNC_STAGES=2 -> go=1 at the 4th edge after strobe sampled; state=1.
- Stop with drain: in RUN, core_stop pulse with core_busy=1 for 3 cycles -> go=0 next edge, state=2 for 3 cycles, then irq=1, irq_n=0 (irq_mask=0), state=0.
- Deferred start: during DRAIN, write 16'h3030 data 8'h20 -> on drain exit irq=1 and state=1, go=1; with an abort (data 8'h00) also written before drain ends -> state=0.
- IRQ clear race: irq=1; read of 16'h3031 completes in the same cycle as a DRAIN exit -> irq stays 1. A read completion alone -> irq=0 and irq_n=1 one cycle later.
- Mask: irq=1, irq_mask 0->1 -> irq_n 0->1 one cycle later, irq still 1. Abort in RUN (write 16'h3030 data 8'h00) -> go=0, irq unchanged.
